// File: rtl/quad_pkg.sv
// Shared quadrature-encoder types: AB codes, direction enum
// and the Gray-code transition classifier.
package quad_pkg;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW,
    DIR_ILLEGAL
  } quad_dir_t;

  function automatic quad_dir_t quad_dir(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    logic [1:0] fwd;
    logic [1:0] bwd;
    quad_dir_t  d;
    unique case (prev)
      AB_00: begin
        fwd = AB_01;
        bwd = AB_10;
      end
      AB_01: begin
        fwd = AB_11;
        bwd = AB_00;
      end
      AB_11: begin
        fwd = AB_10;
        bwd = AB_01;
      end
      default: begin
        fwd = AB_00;
        bwd = AB_11;
      end
    endcase
    unique case (1'b1)
      (cur == prev): d = DIR_NONE;
      (cur == fwd):  d = DIR_CW;
      (cur == bwd):  d = DIR_CCW;
      default:       d = DIR_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/quad_transition_decode.sv
// Combinational prev/cur AB -> direction classifier.
// Ports: prev_ab, cur_ab in; dir out (quad_dir_t).
module quad_transition_decode
  import quad_pkg::*;
(
  input  logic [1:0] prev_ab,
  input  logic [1:0] cur_ab,
  output quad_dir_t  dir
);

  assign dir = quad_dir(prev_ab, cur_ab);

endmodule

// File: rtl/quadrature_decoder.sv
// Rotary encoder A/B decoder: detent position, step pulses,
// sticky moved/err. In: clk reset a_in b_in clr rd_ack.
// Out: position cw_pulse ccw_pulse moved err.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int POS_W            = 16,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_in,
  input  logic                    b_in,
  input  logic                    clr,
  input  logic                    rd_ack,
  output logic signed [POS_W-1:0] position,
  output logic                    cw_pulse,
  output logic                    ccw_pulse,
  output logic                    moved,
  output logic                    err
);

  localparam logic signed [3:0] SPD_P =
    4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] SPD_N = -SPD_P;

  logic [1:0]        cur_ab;
  logic [1:0]        prev_ab;
  logic              loaded;
  logic              primed;
  logic signed [2:0] accum;

  quad_dir_t         dir;
  logic signed [3:0] acc_ext;
  logic signed [3:0] acc_inc;
  logic signed [3:0] acc_dec;
  logic signed [2:0] acc_d;
  logic              step_cw;
  logic              step_ccw;
  logic              illegal;

  quad_transition_decode u_dec (
    .prev_ab (prev_ab),
    .cur_ab  (cur_ab),
    .dir     (dir)
  );

  // prev_ab is only meaningful once two samples exist;
  // primed gates decode so the power-up AB never counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_ab  <= AB_00;
      prev_ab <= AB_00;
      loaded  <= 1'b0;
      primed  <= 1'b0;
    end else begin
      cur_ab <= {a_in, b_in};
      loaded <= 1'b1;
      if (loaded) begin
        prev_ab <= cur_ab;
        primed  <= 1'b1;
      end
    end
  end

  // Extend to 4 bits so reaching +4 is representable.
  assign acc_ext = {accum[2], accum};
  assign acc_inc = acc_ext + 4'sd1;
  assign acc_dec = acc_ext - 4'sd1;

  always_comb begin
    acc_d    = accum;
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    illegal  = 1'b0;
    if (primed) begin
      unique case (dir)
        DIR_NONE: begin
          acc_d = accum;
        end
        DIR_CW: begin
          if (acc_inc == SPD_P) begin
            step_cw = 1'b1;
            acc_d   = '0;
          end else begin
            acc_d = acc_inc[2:0];
          end
        end
        DIR_CCW: begin
          if (acc_dec == SPD_N) begin
            step_ccw = 1'b1;
            acc_d    = '0;
          end else begin
            acc_d = acc_dec[2:0];
          end
        end
        DIR_ILLEGAL: begin
          illegal = 1'b1;
          acc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position  <= '0;
      accum     <= '0;
      cw_pulse  <= 1'b0;
      ccw_pulse <= 1'b0;
      moved     <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      position  <= '0;
      accum     <= '0;
      cw_pulse  <= 1'b0;
      ccw_pulse <= 1'b0;
      moved     <= 1'b0;
      err       <= 1'b0;
    end else begin
      accum     <= acc_d;
      cw_pulse  <= step_cw;
      ccw_pulse <= step_ccw;
      if (step_cw)
        position <= position + POS_W'(1);
      else if (step_ccw)
        position <= position - POS_W'(1);
      if (illegal)
        err <= 1'b1;
      // A step wins over a same-cycle read acknowledge.
      if (step_cw || step_ccw)
        moved <= 1'b1;
      else if (rd_ack)
        moved <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized + directed bench for quadrature_decoder,
// two instances (4 and 1 steps/detent) vs a phase model.
module tb_quadrature_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_in;
  logic        b_in;
  logic        clr;
  logic        rd_ack;
  logic [15:0] pos0, pos1;
  logic        cw0, ccw0, mv0, er0;
  logic        cw1, ccw1, mv1, er1;

  always #5 clk = ~clk;

  quadrature_decoder #(
    .POS_W(16), .STEPS_PER_DETENT(4)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .a_in(a_in), .b_in(b_in),
    .clr(clr), .rd_ack(rd_ack),
    .position(pos0), .cw_pulse(cw0),
    .ccw_pulse(ccw0), .moved(mv0), .err(er0)
  );

  quadrature_decoder #(
    .POS_W(16), .STEPS_PER_DETENT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .a_in(a_in), .b_in(b_in),
    .clr(clr), .rd_ack(rd_ack),
    .position(pos1), .cw_pulse(cw1),
    .ccw_pulse(ccw1), .moved(mv1), .err(er1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Reference model: position on the Gray cycle as a
  // phase 0..3; step count via plain integer arithmetic.
  int       spd[2] = '{4, 1};
  int       m_pos[2];
  int       m_acc[2];
  bit       m_err[2];
  bit       m_mv[2];
  bit       m_cw[2];
  bit       m_ccw[2];
  logic [1:0] h_new, h_old;
  int       seen;
  int       cnt_cw0, cnt_ccw0;
  int       cph;

  function automatic int ph(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_acc[i] = 0;
      m_err[i] = 0; m_mv[i] = 0;
      m_cw[i] = 0;  m_ccw[i] = 0;
    end
    h_new = 2'b00; h_old = 2'b00; seen = 0;
  endtask

  task automatic model_edge(input logic [1:0] ab,
                            input bit c, input bit k);
    int d;
    int na;
    bit ill;
    for (int i = 0; i < 2; i++) begin
      d = 0; ill = 0;
      if (seen >= 2)
        d = (ph(h_new) - ph(h_old) + 4) % 4;
      na = m_acc[i];
      if (d == 1) na++;
      if (d == 3) na--;
      if (d == 2) begin ill = 1; na = 0; end
      m_cw[i] = (na == spd[i]);
      m_ccw[i] = (na == -spd[i]);
      if (m_cw[i] || m_ccw[i]) na = 0;
      if (c) begin
        m_pos[i] = 0; m_acc[i] = 0;
        m_err[i] = 0; m_mv[i] = 0;
        m_cw[i] = 0;  m_ccw[i] = 0;
      end else begin
        m_acc[i] = na;
        if (m_cw[i])  m_pos[i] = (m_pos[i] + 1) & 16'hFFFF;
        if (m_ccw[i]) m_pos[i] = (m_pos[i] + 65535) & 16'hFFFF;
        if (ill) m_err[i] = 1;
        if (m_cw[i] || m_ccw[i]) m_mv[i] = 1;
        else if (k) m_mv[i] = 0;
      end
    end
    h_old = h_new;
    h_new = ab;
    if (seen < 2) seen++;
  endtask

  task automatic check_all();
    cnt_cw0  += int'(cw0);
    cnt_ccw0 += int'(ccw0);
    chk("pos0", pos0, m_pos[0]);
    chk("cw0",  cw0,  m_cw[0]);
    chk("ccw0", ccw0, m_ccw[0]);
    chk("mv0",  mv0,  m_mv[0]);
    chk("err0", er0,  m_err[0]);
    chk("pos1", pos1, m_pos[1]);
    chk("cw1",  cw1,  m_cw[1]);
    chk("ccw1", ccw1, m_ccw[1]);
    chk("mv1",  mv1,  m_mv[1]);
    chk("err1", er1,  m_err[1]);
  endtask

  task automatic tick(input logic [1:0] ab,
                      input bit c, input bit k);
    a_in = ab[1]; b_in = ab[0];
    clr = c; rd_ack = k;
    @(posedge clk);
    model_edge(ab, c, k);
    #1;
    check_all();
  endtask

  task automatic go(input logic [1:0] ab, input int hold);
    repeat (hold) tick(ab, 1'b0, 1'b0);
  endtask

  task automatic detent_cw(input int h);
    go(2'b10, h); go(2'b00, h);
    go(2'b01, h); go(2'b11, h);
  endtask

  task automatic detent_ccw(input int h);
    go(2'b01, h); go(2'b00, h);
    go(2'b10, h); go(2'b11, h);
  endtask

  // Async reset asserted between clock edges.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_pos0", pos0, 0);
    chk("rst_pos1", pos1, 0);
    chk("rst_cw0", cw0, 0);
    chk("rst_ccw0", ccw0, 0);
    chk("rst_mv0", mv0, 0);
    chk("rst_err0", er0, 0);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_in = 1'b1; b_in = 1'b1;
    clr = 1'b0; rd_ack = 1'b0;
    model_reset();
    #22;
    chk("init_pos0", pos0, 0);
    chk("init_cw0", cw0, 0);
    chk("init_ccw0", ccw0, 0);
    chk("init_mv0", mv0, 0);
    chk("init_err0", er0, 0);
    #1 reset = 1'b0;

    // 1: one CW detent from a powered-up AB=11
    cnt_cw0 = 0; cnt_ccw0 = 0;
    go(2'b11, 5);
    detent_cw(5);
    chk("t1_pos", pos0, 1);
    chk("t1_ncw", cnt_cw0, 1);
    chk("t1_mv", mv0, 1);
    chk("t1_err", er0, 0);

    // 2: three CW, ack, two CCW
    tick(2'b11, 1'b1, 1'b0);
    go(2'b11, 2);
    repeat (3) detent_cw(2);
    go(2'b11, 2);
    chk("t2_pos3", pos0, 3);
    tick(2'b11, 1'b0, 1'b1);
    chk("t2_ack", mv0, 0);
    cnt_ccw0 = 0;
    repeat (2) detent_ccw(2);
    go(2'b11, 2);
    chk("t2_pos", pos0, 1);
    chk("t2_nccw", cnt_ccw0, 2);
    chk("t2_mv", mv0, 1);

    // 3: partial detent then a full one
    cnt_cw0 = 0; cnt_ccw0 = 0;
    go(2'b10, 2); go(2'b00, 2);
    go(2'b10, 2); go(2'b11, 3);
    chk("t3_pos", pos0, 1);
    chk("t3_np", cnt_cw0 + cnt_ccw0, 0);
    detent_cw(1);
    go(2'b11, 2);
    chk("t3_full", pos0, 2);

    // 4: illegal jump, recover, clear
    go(2'b00, 3);
    chk("t4_err", er0, 1);
    chk("t4_pos", pos0, 2);
    go(2'b11, 3);
    detent_cw(2);
    go(2'b11, 2);
    chk("t4_next", pos0, 3);
    tick(2'b11, 1'b1, 1'b0);
    chk("t4_clr_err", er0, 0);
    chk("t4_clr_pos", pos0, 0);

    // 5: wrap, using the one-step-per-edge instance
    go(2'b11, 2);
    tick(2'b11, 1'b1, 1'b0);
    cph = 2;
    for (int i = 0; i < 32767; i++) begin
      cph = (cph + 1) % 4;
      go(ab_of(cph), 1);
    end
    go(ab_of(cph), 1);
    chk("t5_max", pos1, 16'h7FFF);
    cph = (cph + 1) % 4;
    go(ab_of(cph), 2);
    chk("t5_wrap_up", pos1, 16'h8000);
    cph = (cph + 3) % 4;
    go(ab_of(cph), 2);
    chk("t5_wrap_dn", pos1, 16'h7FFF);
    go(2'b11, 3);
    tick(2'b11, 1'b1, 1'b0);
    go(2'b11, 2);
    detent_ccw(2);
    go(2'b11, 2);
    chk("t5_neg", pos0, 16'hFFFF);

    // 6: step with ack; step with clr; reset mid-detent
    go(2'b10, 1); go(2'b00, 1);
    go(2'b01, 1); go(2'b11, 1);
    tick(2'b11, 1'b0, 1'b1);
    chk("t6_ack_cw", cw0, 1);
    chk("t6_ack_mv", mv0, 1);
    go(2'b11, 2);
    go(2'b10, 1); go(2'b00, 1);
    go(2'b01, 1); go(2'b11, 1);
    tick(2'b11, 1'b1, 1'b0);
    chk("t6_clr_pos", pos0, 0);
    chk("t6_clr_cw", cw0, 0);
    go(2'b11, 2);
    cnt_cw0 = 0;
    go(2'b10, 1); go(2'b00, 1);
    do_reset();
    go(2'b01, 1); go(2'b11, 3);
    chk("t6_rst_pos", pos0, 0);
    chk("t6_rst_ncw", cnt_cw0, 0);

    // Randomized walk with clears, acks and resets
    cph = 2;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 31));
      if (r == 0)      cph = (cph + 2) % 4;
      else if (r < 12) cph = cph;
      else if (r < 22) cph = (cph + 1) % 4;
      else             cph = (cph + 3) % 4;
      tick(ab_of(cph),
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
